fetch_miss_ctrl: RTL and testbench
==================================

Name: fetch_miss_ctrl

Overview:
Sequences L1I refills for the fetch stage whenever the branch predictor's L0 line misses. It holds one outstanding L1I request, forwards the returned line and its PC to fetch, and drops stale responses after a flush. It sits between the branch predictor (PC/hit source), the L1I request/response port, and fetch (line consumer). It back-pressures the predictor while a miss is in flight.

Parameters:
PC_WIDTH, 64, width of predicted PC and request address
CACHE_LINE_WIDTH, 64, line size in bytes; BLOCK_OFFSET_BITS = $clog2(CACHE_LINE_WIDTH)
PERF_CNT_WIDTH, 32, width of the miss and stall performance counters

Ports:
clk_in  input  1  clock
rst_N_in  input  1  reset, asynchronous, active-low
flush_in  input  1  misprediction flush
bp_pc_valid  input  1  predictor presents a valid PC this cycle
bp_l0_hit  input  1  L0 holds the line for pred_pc (qualified by bp_pc_valid)
pred_pc  input  PC_WIDTH  predicted PC
bp_ready  output  1  controller accepts a new PC (high only in IDLE)
l1i_req_valid  output  1  L1I request valid
l1i_req_ready  input  1  L1I accepts request
l1i_req_addr  output  PC_WIDTH  line-aligned request address
l1i_resp_valid  input  1  L1I response valid (one-cycle pulse)
l1i_resp_line  input  8 x CACHE_LINE_WIDTH (unpacked bytes)  response line
l1i_line_valid  output  1  registered: forwarded line valid for fetch
l1i_line_out  output  8 x CACHE_LINE_WIDTH  registered forwarded line
l1i_pc_out  output  PC_WIDTH  full (unaligned) miss PC paired with l1i_line_out
miss_count  output  PERF_CNT_WIDTH  saturating count of L1I requests accepted
stall_count  output  PERF_CNT_WIDTH  saturating count of cycles with bp_ready low

Behaviour:
- Reset (async, rst_N_in low): state=IDLE; all outputs 0 except bp_ready=1; captured PC/line registers 0; counters 0.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: bp_ready=1. If bp_pc_valid & ~bp_l0_hit & ~flush_in: capture miss_pc=pred_pc, go REQ. A hit or flush_in stays in IDLE.
- REQ: l1i_req_valid=1, l1i_req_addr = miss_pc with low BLOCK_OFFSET_BITS cleared. On l1i_req_ready: increment miss_count, go WAIT. flush_in (with or without ready): go IDLE, no count. valid is withdrawn only on flush.
- WAIT: on l1i_resp_valid & ~flush_in: register line and miss_pc; l1i_line_valid=1 the next cycle for exactly one cycle; go IDLE. On flush_in & ~l1i_resp_valid: go DRAIN. On flush_in & l1i_resp_valid in the same cycle: drop the response, go IDLE.
- DRAIN: ignore all predictor input. On l1i_resp_valid: drop the line, go IDLE. flush_in stays in DRAIN.
- Latency: miss in IDLE at cycle t gives l1i_req_valid at t+1. Response at cycle r gives l1i_line_valid at r+1. Best-case round trip is 3 cycles plus L1I latency.
- flush_in also clears l1i_line_valid on the following cycle (the pending forward is suppressed).
- l1i_resp_valid in IDLE or REQ is a protocol error: ignored, no state change (assertion in bench).
- Counters saturate at all-ones and do not wrap. stall_count increments every cycle that bp_ready=0.
- Reset mid-miss returns to IDLE. Any later response is then treated as unsolicited and ignored.

Decomposition:
- op_pkg: typedef enum logic [1:0] fetch_miss_state_e {FM_IDLE, FM_REQ, FM_WAIT, FM_DRAIN}, and constant FETCH_LINE_BYTES = 64.
- Sub-module sat_counter #(WIDTH): increment enable, async active-low reset, saturating. Instantiated twice, for miss_count and stall_count.

Test Plan:
- Miss/refill: pred_pc=0x1044, miss at t0, l1i_req_ready at t1, response at t4 with byte[i]=i -> l1i_req_addr=0x1040 at t1; l1i_line_valid=1 only at t5; l1i_pc_out=0x1044; miss_count=1; bp_ready low t1..t4.
- L0 hit: 10 consecutive bp_pc_valid & bp_l0_hit cycles -> l1i_req_valid never asserts; miss_count=0; stall_count=0.
- Flush in WAIT: request accepted, flush at t2, response at t5 -> state DRAIN t3..t5; l1i_line_valid stays 0; IDLE at t6; new miss at t6 issues request at t7.
- Flush and response same cycle in WAIT -> no l1i_line_valid; IDLE next cycle; no DRAIN.
- Back-pressure: l1i_req_ready low for 4 cycles in REQ -> l1i_req_valid and addr stable; flush on cycle 3 -> valid drops next cycle; miss_count unchanged.
- Async reset: assert rst_N_in mid-WAIT between clock edges -> outputs 0 and bp_ready=1 immediately; a stale response after release is ignored.

Source files
------------

// File: rtl/op_pkg.sv
// Shared types and constants for the fetch-side L1I miss controller.
package op_pkg;

    typedef enum logic [1:0] {
        FM_IDLE  = 2'd0,
        FM_REQ   = 2'd1,
        FM_WAIT  = 2'd2,
        FM_DRAIN = 2'd3
    } fetch_miss_state_e;

    localparam int FETCH_LINE_BYTES = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count enabled cycles until the all-ones ceiling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= {WIDTH{1'b0}};
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_miss_ctrl.sv
// L1I refill sequencer for L0 misses: one outstanding request, forwards the
// returned line with its PC to fetch, and discards responses orphaned by a flush.
module fetch_miss_ctrl
    import op_pkg::*;
#(
    parameter int PC_WIDTH         = 64,
    parameter int CACHE_LINE_WIDTH = FETCH_LINE_BYTES,
    parameter int PERF_CNT_WIDTH   = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_N_in,
    input  logic                      flush_in,
    input  logic                      bp_pc_valid,
    input  logic                      bp_l0_hit,
    input  logic [PC_WIDTH-1:0]       pred_pc,
    output logic                      bp_ready,
    output logic                      l1i_req_valid,
    input  logic                      l1i_req_ready,
    output logic [PC_WIDTH-1:0]       l1i_req_addr,
    input  logic                      l1i_resp_valid,
    input  logic [7:0]                l1i_resp_line [CACHE_LINE_WIDTH],
    output logic                      l1i_line_valid,
    output logic [7:0]                l1i_line_out [CACHE_LINE_WIDTH],
    output logic [PC_WIDTH-1:0]       l1i_pc_out,
    output logic [PERF_CNT_WIDTH-1:0] miss_count,
    output logic [PERF_CNT_WIDTH-1:0] stall_count
);

    localparam int BLOCK_OFFSET_BITS = $clog2(CACHE_LINE_WIDTH);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK =
        ~((PC_WIDTH'(1) << BLOCK_OFFSET_BITS) - PC_WIDTH'(1));

    fetch_miss_state_e   state_q;
    logic                bp_ready_q;
    logic                req_valid_q;
    logic [PC_WIDTH-1:0] req_addr_q;
    logic [PC_WIDTH-1:0] miss_pc_q;
    logic                line_valid_q;
    logic [PC_WIDTH-1:0] pc_out_q;
    logic [7:0]          line_q [CACHE_LINE_WIDTH];
    logic                miss_inc_s;
    logic                stall_inc_s;

    // Miss sequencing FSM; all fetch/L1I-facing outputs are registered here.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state_q      <= FM_IDLE;
            bp_ready_q   <= 1'b1;
            req_valid_q  <= 1'b0;
            req_addr_q   <= {PC_WIDTH{1'b0}};
            miss_pc_q    <= {PC_WIDTH{1'b0}};
            line_valid_q <= 1'b0;
            pc_out_q     <= {PC_WIDTH{1'b0}};
            for (int i = 0; i < CACHE_LINE_WIDTH; i++) begin
                line_q[i] <= 8'h00;
            end
        end else begin
            line_valid_q <= 1'b0;
            case (state_q)
                FM_IDLE: begin
                    if (bp_pc_valid && !bp_l0_hit && !flush_in) begin
                        state_q     <= FM_REQ;
                        miss_pc_q   <= pred_pc;
                        req_addr_q  <= pred_pc & ALIGN_MASK;
                        req_valid_q <= 1'b1;
                        bp_ready_q  <= 1'b0;
                    end
                end
                FM_REQ: begin
                    if (flush_in) begin
                        state_q     <= FM_IDLE;
                        req_valid_q <= 1'b0;
                        bp_ready_q  <= 1'b1;
                    end else if (l1i_req_ready) begin
                        state_q     <= FM_WAIT;
                        req_valid_q <= 1'b0;
                    end
                end
                FM_WAIT: begin
                    // A flush coinciding with the response drops it without draining.
                    if (l1i_resp_valid) begin
                        state_q    <= FM_IDLE;
                        bp_ready_q <= 1'b1;
                        if (!flush_in) begin
                            line_valid_q <= 1'b1;
                            line_q       <= l1i_resp_line;
                            pc_out_q     <= miss_pc_q;
                        end
                    end else if (flush_in) begin
                        state_q <= FM_DRAIN;
                    end
                end
                FM_DRAIN: begin
                    if (l1i_resp_valid) begin
                        state_q    <= FM_IDLE;
                        bp_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= FM_IDLE;
                    bp_ready_q  <= 1'b1;
                    req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign miss_inc_s  = (state_q == FM_REQ) && l1i_req_ready && !flush_in;
    assign stall_inc_s = !bp_ready_q;

    sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_miss_cnt (
        .clk_i   (clk_in),
        .rst_ni  (rst_N_in),
        .inc_i   (miss_inc_s),
        .count_o (miss_count)
    );

    sat_counter #(.WIDTH(PERF_CNT_WIDTH)) u_stall_cnt (
        .clk_i   (clk_in),
        .rst_ni  (rst_N_in),
        .inc_i   (stall_inc_s),
        .count_o (stall_count)
    );

    assign bp_ready       = bp_ready_q;
    assign l1i_req_valid  = req_valid_q;
    assign l1i_req_addr   = req_addr_q;
    assign l1i_line_valid = line_valid_q;
    assign l1i_line_out   = line_q;
    assign l1i_pc_out     = pc_out_q;

endmodule

// File: tb/tb_fetch_miss_ctrl.sv
// Bench for fetch_miss_ctrl: directed vector table, hand sequences for async
// reset, and random traffic against a transaction-level reference model.
module tb_fetch_miss_ctrl;

    localparam int PCW = 64;
    localparam int LB  = 64;
    localparam int CW  = 32;

    logic           clk_in = 1'b0;
    logic           rst_N_in;
    logic           flush_in;
    logic           bp_pc_valid;
    logic           bp_l0_hit;
    logic [PCW-1:0] pred_pc;
    logic           bp_ready;
    logic           l1i_req_valid;
    logic           l1i_req_ready;
    logic [PCW-1:0] l1i_req_addr;
    logic           l1i_resp_valid;
    logic [7:0]     l1i_resp_line [LB];
    logic           l1i_line_valid;
    logic [7:0]     l1i_line_out [LB];
    logic [PCW-1:0] l1i_pc_out;
    logic [CW-1:0]  miss_count;
    logic [CW-1:0]  stall_count;

    fetch_miss_ctrl #(.PC_WIDTH(PCW), .CACHE_LINE_WIDTH(LB), .PERF_CNT_WIDTH(CW)) dut (
        .clk_in         (clk_in),
        .rst_N_in       (rst_N_in),
        .flush_in       (flush_in),
        .bp_pc_valid    (bp_pc_valid),
        .bp_l0_hit      (bp_l0_hit),
        .pred_pc        (pred_pc),
        .bp_ready       (bp_ready),
        .l1i_req_valid  (l1i_req_valid),
        .l1i_req_ready  (l1i_req_ready),
        .l1i_req_addr   (l1i_req_addr),
        .l1i_resp_valid (l1i_resp_valid),
        .l1i_resp_line  (l1i_resp_line),
        .l1i_line_valid (l1i_line_valid),
        .l1i_line_out   (l1i_line_out),
        .l1i_pc_out     (l1i_pc_out),
        .miss_count     (miss_count),
        .stall_count    (stall_count)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic           v, h;
        logic [PCW-1:0] pc;
        logic           rdy, resp, fl;
        logic           e_bp, e_rq;
        logic [PCW-1:0] e_addr;
        logic           e_lv;
        logic [PCW-1:0] e_pcout;
        logic [CW-1:0]  e_miss;
    } vec_t;

    vec_t tbl[$];

    // Reference model: one miss at a time, tracked as pending/outstanding/discard.
    logic           m_pend, m_out, m_disc, m_lv;
    logic [PCW-1:0] m_pc, m_pcout;
    logic [CW-1:0]  m_miss, m_stall;
    logic [7:0]     m_line [LB];
    logic           allow_stale;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int line_diff(input logic [7:0] e [LB]);
        int n = 0;
        for (int i = 0; i < LB; i++) if (l1i_line_out[i] !== e[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_out = 1'b0; m_disc = 1'b0; m_lv = 1'b0;
        m_pc = '0; m_pcout = '0; m_miss = '0; m_stall = '0;
        for (int i = 0; i < LB; i++) m_line[i] = 8'h00;
    endtask

    task automatic model_step();
        logic was_idle;
        was_idle = !(m_pend || m_out);
        assert (!(l1i_resp_valid && !m_out) || allow_stale)
            else $error("protocol: L1I response with no request outstanding");
        m_lv = 1'b0;
        if (was_idle) begin
            if (bp_pc_valid && !bp_l0_hit && !flush_in) begin
                m_pend = 1'b1;
                m_pc   = pred_pc;
            end
        end else if (m_pend) begin
            if (flush_in) m_pend = 1'b0;
            else if (l1i_req_ready) begin
                m_pend = 1'b0;
                m_out  = 1'b1;
                if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
            end
        end else begin
            if (l1i_resp_valid) begin
                if (!m_disc && !flush_in) begin
                    m_lv    = 1'b1;
                    m_pcout = m_pc;
                    m_line  = l1i_resp_line;
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (flush_in) begin
                m_disc = 1'b1;
            end
        end
        if (!was_idle && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_model();
        logic [PCW-1:0] mask;
        mask = ~64'd63;
        chk("rnd_bp_ready", 64'(bp_ready), 64'(!(m_pend || m_out)));
        chk("rnd_req_valid", 64'(l1i_req_valid), 64'(m_pend));
        if (m_pend) chk("rnd_req_addr", l1i_req_addr, m_pc & mask);
        chk("rnd_line_valid", 64'(l1i_line_valid), 64'(m_lv));
        chk("rnd_pc_out", l1i_pc_out, m_pcout);
        chk("rnd_miss", 64'(miss_count), 64'(m_miss));
        chk("rnd_stall", 64'(stall_count), 64'(m_stall));
        if (m_lv) chk("rnd_line", 64'(line_diff(m_line)), 64'd0);
    endtask

    task automatic idle_inputs();
        bp_pc_valid = 1'b0; bp_l0_hit = 1'b0; pred_pc = '0;
        l1i_req_ready = 1'b0; l1i_resp_valid = 1'b0; flush_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_N_in = 1'b0;
        idle_inputs();
        allow_stale = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        #1;
    endtask

    function automatic void add(input logic v, input logic h, input logic [PCW-1:0] pc,
                                input logic rdy, input logic resp, input logic fl,
                                input logic bp, input logic rq, input logic [PCW-1:0] addr,
                                input logic lv, input logic [PCW-1:0] pco, input logic [CW-1:0] ms);
        vec_t r;
        r.v = v; r.h = h; r.pc = pc; r.rdy = rdy; r.resp = resp; r.fl = fl;
        r.e_bp = bp; r.e_rq = rq; r.e_addr = addr; r.e_lv = lv; r.e_pcout = pco; r.e_miss = ms;
        tbl.push_back(r);
    endfunction

    logic [7:0] ramp [LB];
    logic [CW-1:0] exp_stall;
    logic prev_bp;

    initial begin
        for (int i = 0; i < LB; i++) begin
            ramp[i] = 8'(i);
            l1i_resp_line[i] = 8'(i);
        end
        do_reset();
        chk("reset_bp_ready", 64'(bp_ready), 64'd1);
        chk("reset_req_valid", 64'(l1i_req_valid), 64'd0);
        chk("reset_line_valid", 64'(l1i_line_valid), 64'd0);
        chk("reset_pc_out", l1i_pc_out, 64'd0);
        chk("reset_counts", 64'({miss_count, stall_count}), 64'd0);

        // L0 hits: no request ever raised.
        for (int i = 0; i < 10; i++) add(1, 1, 64'h100 + 64'(i * 4), 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Miss/refill with 3-cycle L1I wait.
        add(1, 0, 64'h1044, 0, 0, 0, 0, 1, 64'h1040, 0, 0, 0);
        add(0, 0, 64'h0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 64'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 64'h0, 0, 1, 0, 1, 0, 0, 1, 64'h1044, 1);
        add(0, 0, 64'h0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        // Flush in WAIT, drain until the late response, then a fresh miss.
        add(1, 0, 64'h2008, 0, 0, 0, 0, 1, 64'h2000, 0, 0, 1);
        add(0, 0, 64'h0, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 0, 64'h0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
        add(1, 0, 64'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 0, 64'h0, 0, 0, 1, 0, 0, 0, 0, 0, 2);
        add(0, 0, 64'h0, 0, 1, 0, 1, 0, 0, 0, 0, 2);
        add(1, 0, 64'h4010, 0, 0, 0, 0, 1, 64'h4000, 0, 0, 2);
        add(0, 0, 64'h0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        // Flush and response together: dropped, straight back to idle.
        add(0, 0, 64'h0, 0, 1, 1, 1, 0, 0, 0, 0, 3);
        add(0, 0, 64'h0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        // Back-pressure then flush while requesting.
        add(1, 0, 64'h5030, 0, 0, 0, 0, 1, 64'h5000, 0, 0, 3);
        add(0, 0, 64'h0, 0, 0, 0, 0, 1, 64'h5000, 0, 0, 3);
        add(0, 0, 64'h0, 0, 0, 0, 0, 1, 64'h5000, 0, 0, 3);
        add(0, 0, 64'h0, 0, 0, 1, 1, 0, 0, 0, 0, 3);
        add(0, 0, 64'h0, 0, 0, 0, 1, 0, 0, 0, 0, 3);
        // Miss coincident with flush in idle is ignored.
        add(1, 0, 64'h6000, 0, 0, 1, 1, 0, 0, 0, 0, 3);

        exp_stall = '0;
        prev_bp = 1'b1;
        foreach (tbl[k]) begin
            bp_pc_valid = tbl[k].v; bp_l0_hit = tbl[k].h; pred_pc = tbl[k].pc;
            l1i_req_ready = tbl[k].rdy; l1i_resp_valid = tbl[k].resp; flush_in = tbl[k].fl;
            if (!prev_bp) exp_stall = exp_stall + 32'd1;
            cycle();
            chk($sformatf("vec%0d_bp_ready", k), 64'(bp_ready), 64'(tbl[k].e_bp));
            chk($sformatf("vec%0d_req_valid", k), 64'(l1i_req_valid), 64'(tbl[k].e_rq));
            if (tbl[k].e_rq) chk($sformatf("vec%0d_req_addr", k), l1i_req_addr, tbl[k].e_addr);
            chk($sformatf("vec%0d_line_valid", k), 64'(l1i_line_valid), 64'(tbl[k].e_lv));
            if (tbl[k].e_lv) begin
                chk($sformatf("vec%0d_pc_out", k), l1i_pc_out, tbl[k].e_pcout);
                chk($sformatf("vec%0d_line", k), 64'(line_diff(ramp)), 64'd0);
            end
            chk($sformatf("vec%0d_miss", k), 64'(miss_count), 64'(tbl[k].e_miss));
            chk($sformatf("vec%0d_stall", k), 64'(stall_count), 64'(exp_stall));
            prev_bp = tbl[k].e_bp;
        end

        // Async reset mid-WAIT, then a stale response after release.
        do_reset();
        bp_pc_valid = 1'b1; pred_pc = 64'h7044;
        cycle();
        idle_inputs(); l1i_req_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        #2;
        rst_N_in = 1'b0;
        #1;
        chk("arst_bp_ready", 64'(bp_ready), 64'd1);
        chk("arst_req_valid", 64'(l1i_req_valid), 64'd0);
        chk("arst_line_valid", 64'(l1i_line_valid), 64'd0);
        chk("arst_miss", 64'(miss_count), 64'd0);
        chk("arst_stall", 64'(stall_count), 64'd0);
        model_reset();
        @(negedge clk_in);
        rst_N_in = 1'b1;
        #1;
        allow_stale = 1'b1;
        l1i_resp_valid = 1'b1;
        cycle();
        l1i_resp_valid = 1'b0;
        allow_stale = 1'b0;
        chk("stale_line_valid", 64'(l1i_line_valid), 64'd0);
        chk("stale_bp_ready", 64'(bp_ready), 64'd1);
        chk("stale_pc_out", l1i_pc_out, 64'd0);
        cycle();
        chk("stale_after_line_valid", 64'(l1i_line_valid), 64'd0);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bp_pc_valid    = ($urandom % 4) != 0;
            bp_l0_hit      = ($urandom % 2) != 0;
            pred_pc        = {$urandom, $urandom};
            l1i_req_ready  = ($urandom % 3) == 0;
            flush_in       = ($urandom % 10) == 0;
            l1i_resp_valid = m_out && (($urandom % 4) == 0);
            for (int i = 0; i < LB; i++) l1i_resp_line[i] = 8'($urandom);
            cycle();
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
